// File: rtl/spart_pkg.sv
// spart_pkg: types and constants shared by the SPART transmitter and receiver.
//   tx_state_t          transmit FSM state encoding
//   ADDR_*              ioaddr decode values on the processor-side bus
//   SPART_DEFAULT_DIV   divisor loaded at reset (clk cycles per bit)
//   SPART_MIN_DIV       smallest divisor honoured; smaller values clamp to it
//   eff_div()           clamp helper used when a frame starts
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] ADDR_BUF   = 2'b00;
    localparam logic [1:0] ADDR_STAT  = 2'b01;
    localparam logic [1:0] ADDR_DIVLO = 2'b10;
    localparam logic [1:0] ADDR_DIVHI = 2'b11;

    localparam logic [15:0] SPART_DEFAULT_DIV = 16'd2604;
    localparam logic [15:0] SPART_MIN_DIV     = 16'd16;

    function automatic logic [15:0] eff_div(input logic [15:0] div,
                                            input logic [15:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/spart_tx_if.sv
// spart_tx_if: processor-side bus plus serial/status outputs of the SPART
// transmitter.
//   iocs, iorw, ioaddr, wdata   bus from the processor (master drives)
//   txd, tbr, tx_busy           line and status outputs (slave drives)
interface spart_tx_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] wdata;
    logic       txd;
    logic       tbr;
    logic       tx_busy;

    modport master (
        output iocs, iorw, ioaddr, wdata,
        input  txd, tbr, tx_busy
    );

    modport slave (
        input  iocs, iorw, ioaddr, wdata,
        output txd, tbr, tx_busy
    );

endinterface

// File: rtl/spart_baud_cnt.sv
// spart_baud_cnt: loadable 16-bit baud down-counter.
//   clk, rst   clock, synchronous active-high reset
//   i_load     latch i_div as the reload value and restart the count
//   i_div      divisor (clk cycles per bit), expected >= 1
//   o_tick     high in the last cycle of each bit period (count == 0)
module spart_baud_cnt
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_div,
    output logic        o_tick
);

    logic [15:0] r_cnt;
    logic [15:0] r_reload;

    // The reload value is captured only on i_load, so a divisor change
    // elsewhere never alters the rate of a period already in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_reload <= SPART_MIN_DIV;
        end else if (i_load) begin
            r_reload <= i_div;
            r_cnt    <= i_div - 16'd1;
        end else if (r_cnt == 16'd0) begin
            r_cnt <= r_reload - 16'd1;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    assign o_tick = (r_cnt == 16'd0);

endmodule

// File: rtl/spart_tx.sv
// spart_tx: SPART transmit half. Takes bytes from the processor bus into a
// one-entry holding buffer and serialises them as 8N1, LSB first, on txd.
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     iocs/iorw/ioaddr/wdata in; txd, tbr, tx_busy out
//     ioaddr 00     transmit buffer write (dropped while tbr = 0)
//     ioaddr 01     ignored here (status is read elsewhere)
//     ioaddr 10/11  divisor low/high byte, used from the next frame start
// Build option SPART_TX_PARITY_EN: inserts an even-parity bit after DATA.
//
// state  | meaning
// IDLE   | line idle high, waiting for a full holding buffer
// START  | start bit (0), one baud period
// DATA   | eight data bits, LSB first, one baud period each
// PARITY | even parity of the data byte (parity build only)
// STOP   | stop bit (1); last cycle may chain straight into START
module spart_tx
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = SPART_DEFAULT_DIV,
    parameter logic [15:0] MIN_DIV     = SPART_MIN_DIV
) (
    input  logic       clk,
    input  logic       rst,
    spart_tx_if.slave  bus
);

    logic        w_wr;
    logic        w_wr_buf;
    logic        w_wr_divlo;
    logic        w_wr_divhi;
    logic        w_xfer;
    logic        w_accept;
    logic        w_tick;
    logic [15:0] w_div_eff;

    logic [15:0] r_div;
    logic [7:0]  r_hold_data;
    logic        r_hold_valid;
    tx_state_t   r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_txd;
    logic        r_busy;
`ifdef SPART_TX_PARITY_EN
    logic        r_parity;
`endif

    // ADDR_STAT writes decode to nothing in this block.
    assign w_wr       = bus.iocs & ~bus.iorw;
    assign w_wr_buf   = w_wr & (bus.ioaddr == ADDR_BUF);
    assign w_wr_divlo = w_wr & (bus.ioaddr == ADDR_DIVLO);
    assign w_wr_divhi = w_wr & (bus.ioaddr == ADDR_DIVHI);

    assign w_xfer = r_hold_valid &
                    ((r_state == IDLE) | ((r_state == STOP) & w_tick));

    // The buffer frees up on the same edge as a transfer, so a write landing
    // in that cycle is kept even though tbr still shows 0.
    assign w_accept = w_wr_buf & (~r_hold_valid | w_xfer);

    assign w_div_eff = eff_div(r_div, MIN_DIV);

    spart_baud_cnt u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_xfer),
        .i_div  (w_div_eff),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= DEFAULT_DIV;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_wr_divlo) r_div[7:0]  <= bus.wdata;
            if (w_wr_divhi) r_div[15:8] <= bus.wdata;
            if (w_accept) begin
                r_hold_data  <= bus.wdata;
                r_hold_valid <= 1'b1;
            end else if (w_xfer) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef SPART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_xfer) begin
            // Only reachable from IDLE or the final STOP cycle.
            r_state   <= START;
            r_txd     <= 1'b0;
            r_busy    <= 1'b1;
            r_shift   <= r_hold_data;
            r_bit_cnt <= '0;
`ifdef SPART_TX_PARITY_EN
            r_parity  <= ^r_hold_data;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_txd   <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end
                end
`ifdef SPART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.txd     = r_txd;
    assign bus.tbr     = ~r_hold_valid;
    assign bus.tx_busy = r_busy;

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: scoreboard bench for spart_tx. Bytes are queued as they are
// written; a line decoder samples txd mid-bit and each test pops and compares.
module tb_spart_tx;
    import spart_pkg::*;

`ifdef SPART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    spart_tx_if u_if ();

    spart_tx u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        u_if.iocs   = 1'b1;
        u_if.iorw   = 1'b0;
        u_if.ioaddr = a;
        u_if.wdata  = d;
        @(posedge clk);
        #1;
        u_if.iocs = 1'b0;
        u_if.iorw = 1'b1;
    endtask

    task automatic set_div(input logic [15:0] dv);
        bus_write(ADDR_DIVLO, dv[7:0]);
        bus_write(ADDR_DIVHI, dv[15:8]);
    endtask

    // Waits for a start bit, then samples every slot at its midpoint.
    task automatic capture_frame(input int div, output logic [7:0] d,
                                 output logic par, output logic stp,
                                 output int t0, output bit ok);
        int n;
        ok = 1'b0; d = '0; par = 1'b0; stp = 1'b0; t0 = 0; n = 0;
        @(negedge clk);
        while (u_if.txd !== 1'b0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (u_if.txd !== 1'b0) return;
        t0 = cyc;
        repeat (div / 2) @(negedge clk);
        if (u_if.txd !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            d[i] = u_if.txd;
        end
`ifdef SPART_TX_PARITY_EN
        repeat (div) @(negedge clk);
        par = u_if.txd;
`endif
        repeat (div) @(negedge clk);
        stp = u_if.txd;
        ok = 1'b1;
    endtask

    task automatic wait_idle(input int limit, output int t, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (u_if.tx_busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (u_if.tx_busy === 1'b0);
        t  = cyc;
    endtask

    // Pops the next expected byte and compares it with a decoded frame.
    task automatic score_frame(input string nm, input bit ok,
                               input logic [7:0] d, input logic p,
                               input logic s);
        logic [7:0] e;
        logic [9:0] got, want;
        total++;
        if (!ok || exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got no frame (ok=%0b queued=%0d) want a frame", nm, ok, exp_q.size());
        end else begin
            e    = exp_q.pop_front();
            got  = {s, p, d};
            want = {1'b1, (NB == 11) ? ^e : 1'b0, e};
            if (got !== want) begin
                bad++;
                $display("FAIL %s: got stop/par/data=%b want %b", nm, got, want);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (u_if.txd !== 1'b1)     begin bad++; $display("FAIL reset_txd: got %b want 1", u_if.txd); end
        total++; if (u_if.tbr !== 1'b1)     begin bad++; $display("FAIL reset_tbr: got %b want 1", u_if.tbr); end
        total++; if (u_if.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", u_if.tx_busy); end
        rst = 1'b0;
    endtask

    task automatic test_default_a5();
        logic [7:0] d; logic p, s; int t0, te; bit ok, ok2;
        bus_write(ADDR_BUF, 8'hA5);
        exp_q.push_back(8'hA5);
        total++; if (u_if.tbr !== 1'b0) begin bad++; $display("FAIL a5_tbr_after_write: got %b want 0", u_if.tbr); end
        @(posedge clk); #1;
        total++; if (u_if.txd !== 1'b0)     begin bad++; $display("FAIL a5_start_latency: got txd=%b want 0", u_if.txd); end
        total++; if (u_if.tbr !== 1'b1)     begin bad++; $display("FAIL a5_tbr_after_xfer: got %b want 1", u_if.tbr); end
        total++; if (u_if.tx_busy !== 1'b1) begin bad++; $display("FAIL a5_busy: got %b want 1", u_if.tx_busy); end
        capture_frame(2604, d, p, s, t0, ok);
        score_frame("a5_frame", ok, d, p, s);
        wait_idle(40000, te, ok2);
        total++;
        if (!ok2 || (te - t0) != NB * 2604) begin
            bad++; $display("FAIL a5_frame_len: got %0d cycles (idle=%0b) want %0d", te - t0, ok2, NB * 2604);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic p, s; int t0, t1, te; bit ok, ok2;
        set_div(16'd16);
        bus_write(ADDR_BUF, 8'hE7); exp_q.push_back(8'hE7);
        bus_write(ADDR_BUF, 8'h24); exp_q.push_back(8'h24);
        total++; if (u_if.tbr !== 1'b0) begin bad++; $display("FAIL b2b_tbr_full: got %b want 0", u_if.tbr); end
        capture_frame(16, d, p, s, t0, ok);
        score_frame("b2b_frame1", ok, d, p, s);
        total++; if (u_if.tbr !== 1'b0) begin bad++; $display("FAIL b2b_tbr_waiting: got %b want 0", u_if.tbr); end
        capture_frame(16, d, p, s, t1, ok);
        score_frame("b2b_frame2", ok, d, p, s);
        total++; if (t1 - t0 != NB * 16) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", t1 - t0, NB * 16); end
        total++; if (u_if.tbr !== 1'b1) begin bad++; $display("FAIL b2b_tbr_empty: got %b want 1", u_if.tbr); end
        wait_idle(2000, te, ok2);
        total++;
        if (!ok2 || (te - t0) != 2 * NB * 16) begin
            bad++; $display("FAIL b2b_total: got %0d (idle=%0b) want %0d", te - t0, ok2, 2 * NB * 16);
        end
    endtask

    task automatic test_drop();
        logic [7:0] d; logic p, s; int t0, te; bit ok, ok2, extra;
        bus_write(ADDR_BUF, 8'h11); exp_q.push_back(8'h11);
        bus_write(ADDR_BUF, 8'h22); exp_q.push_back(8'h22);
        bus_write(ADDR_BUF, 8'h33);
        capture_frame(16, d, p, s, t0, ok);
        score_frame("drop_frame1", ok, d, p, s);
        capture_frame(16, d, p, s, t0, ok);
        score_frame("drop_frame2", ok, d, p, s);
        wait_idle(2000, te, ok2);
        extra = 1'b0;
        for (int i = 0; i < 2 * NB * 16; i++) begin
            @(negedge clk);
            if (u_if.txd !== 1'b1 || u_if.tx_busy !== 1'b0) extra = 1'b1;
        end
        total++; if (!ok2 || extra) begin bad++; $display("FAIL drop_third: got extra activity=%0b idle=%0b want none", extra, ok2); end
    endtask

    task automatic test_clamp();
        int te; bit ok2;
        set_div(16'd4);
        bus_write(ADDR_BUF, 8'hB5);
        @(posedge clk); #1;
        total++; if (u_if.txd !== 1'b0) begin bad++; $display("FAIL clamp_start: got %b want 0", u_if.txd); end
        repeat (15) @(posedge clk);
        #1;
        total++; if (u_if.txd !== 1'b0) begin bad++; $display("FAIL clamp_start_end: got %b want 0", u_if.txd); end
        @(posedge clk); #1;
        total++; if (u_if.txd !== 1'b1) begin bad++; $display("FAIL clamp_bit0: got %b want 1", u_if.txd); end
        wait_idle(2000, te, ok2);
        total++; if (!ok2) begin bad++; $display("FAIL clamp_idle: got busy want idle"); end
    endtask

    task automatic test_div_midframe();
        logic [7:0] d; logic p, s; int t0, te; bit ok, ok2;
        set_div(16'd16);
        bus_write(ADDR_BUF, 8'h5A); exp_q.push_back(8'h5A);
        bus_write(ADDR_DIVLO, 8'h20);
        capture_frame(16, d, p, s, t0, ok);
        score_frame("mid_frame16", ok, d, p, s);
        wait_idle(2000, te, ok2);
        total++; if (!ok2 || (te - t0) != NB * 16) begin bad++; $display("FAIL mid_len16: got %0d want %0d", te - t0, NB * 16); end
        bus_write(ADDR_BUF, 8'hC3); exp_q.push_back(8'hC3);
        capture_frame(32, d, p, s, t0, ok);
        score_frame("mid_frame32", ok, d, p, s);
        wait_idle(2000, te, ok2);
        total++; if (!ok2 || (te - t0) != NB * 32) begin bad++; $display("FAIL mid_len32: got %0d want %0d", te - t0, NB * 32); end
    endtask

    task automatic test_reset_midframe();
        set_div(16'd16);
        bus_write(ADDR_BUF, 8'hA5);
        @(posedge clk); #1;
        repeat (72) @(posedge clk);
        #1;
        total++; if (u_if.txd !== 1'b0) begin bad++; $display("FAIL rstmid_bit3: got %b want 0", u_if.txd); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (u_if.txd !== 1'b1)     begin bad++; $display("FAIL rstmid_txd: got %b want 1", u_if.txd); end
        total++; if (u_if.tbr !== 1'b1)     begin bad++; $display("FAIL rstmid_tbr: got %b want 1", u_if.tbr); end
        total++; if (u_if.tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", u_if.tx_busy); end
        bus_write(ADDR_BUF, 8'h01);
        @(posedge clk); #1;
        repeat (2603) @(posedge clk);
        #1;
        total++; if (u_if.txd !== 1'b0) begin bad++; $display("FAIL rstmid_div_start: got %b want 0", u_if.txd); end
        @(posedge clk); #1;
        total++; if (u_if.txd !== 1'b1) begin bad++; $display("FAIL rstmid_div_bit0: got %b want 1", u_if.txd); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef SPART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d; logic p, s; int t0; bit ok;
        set_div(16'd16);
        bus_write(ADDR_BUF, 8'hA5); exp_q.push_back(8'hA5);
        bus_write(ADDR_BUF, 8'h07); exp_q.push_back(8'h07);
        capture_frame(16, d, p, s, t0, ok);
        total++; if (!ok || p !== 1'b0) begin bad++; $display("FAIL par_a5: got %b want 0", p); end
        score_frame("par_frame_a5", ok, d, p, s);
        capture_frame(16, d, p, s, t0, ok);
        total++; if (!ok || p !== 1'b1) begin bad++; $display("FAIL par_07: got %b want 1", p); end
        score_frame("par_frame_07", ok, d, p, s);
    endtask
`endif

    initial begin
        u_if.iocs   = 1'b0;
        u_if.iorw   = 1'b1;
        u_if.ioaddr = 2'b00;
        u_if.wdata  = 8'h00;
        test_reset();
        test_default_a5();
        test_back_to_back();
        test_drop();
        test_clamp();
        test_div_midframe();
        test_reset_midframe();
`ifdef SPART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
